// File: rtl/bus_mon_watchdog_pkg.sv
// Shared state encoding and terminal-flag decode for the bus monitor/watchdog.
package bus_mon_watchdog_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DONE    = 3'd2,
    ST_TRAP    = 3'd3,
    ST_HANG    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_e;

  typedef struct packed {
    logic done;
    logic trapped;
    logic hung;
    logic timed_out;
  } term_flags_t;

  // Each terminal state owns exactly one flag, so decoding the state keeps them mutually exclusive.
  function automatic term_flags_t flags_of(input state_e s);
    term_flags_t f;
    f.done      = (s == ST_DONE);
    f.trapped   = (s == ST_TRAP);
    f.hung      = (s == ST_HANG);
    f.timed_out = (s == ST_TIMEOUT);
    return f;
  endfunction

endpackage

// File: rtl/bus_mon_watchdog_if.sv
// Native memory bus (valid/ready handshake) as seen by core, memory and the monitor.
interface bus_mon_watchdog_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );

  // The watchdog only observes; it never drives the bus.
  modport monitor (
    input mem_valid, mem_ready, mem_addr, mem_wstrb, mem_wdata, mem_rdata
  );

endinterface

// File: rtl/bus_watch_chan.sv
// One address-watch channel: address compare, sticky hit, byte-merged write capture.
module bus_watch_chan #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                active,
  input  logic                clear,
  input  logic                wr_xfer,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [ADDR_W-1:0]   watch_addr,
  output logic                hit,
  output logic [DATA_W-1:0]   data
);

  logic              hit_d,  hit_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Merge only the strobed bytes of a matching write; reads never hit.
  always_comb begin
    hit_d  = hit_q;
    data_d = data_q;
    if (clear) begin
      hit_d  = 1'b0;
      data_d = '0;
    end else if (active && wr_xfer && (mem_addr == watch_addr)) begin
      hit_d = 1'b1;
      for (int b = 0; b < DATA_W/8; b++) begin
        if (mem_wstrb[b]) data_d[b*8 +: 8] = mem_wdata[b*8 +: 8];
      end
    end
  end

  // Capture registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_q  <= 1'b0;
      data_q <= '0;
    end else begin
      hit_q  <= hit_d;
      data_q <= data_d;
    end
  end

  assign hit  = hit_q;
  assign data = data_q;

endmodule

// File: rtl/bus_mon_watchdog.sv
// Bus monitor/watchdog: run FSM, event counters, hang/timeout detection, done capture.
//   state      | meaning
//   IDLE    0  | counters held, waiting for enable
//   RUN     1  | counting, watching for terminal conditions
//   DONE    2  | completion write seen
//   TRAP    3  | core trapped
//   HANG    4  | STALL_LIMIT consecutive stall cycles
//   TIMEOUT 5  | TIMEOUT_CYCLES run cycles elapsed
module bus_mon_watchdog
  import bus_mon_watchdog_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                NUM_WATCH      = 2,
  parameter int                CYC_W          = 32,
  parameter logic [ADDR_W-1:0] DONE_ADDR      = 32'h0000_0010,
  parameter int                TIMEOUT_CYCLES = 1_000_000,
  parameter int                STALL_LIMIT    = 1024
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic                          clear,
  bus_mon_watchdog_if.monitor           bus,
  input  logic                          trap,
  input  logic [NUM_WATCH*ADDR_W-1:0]   watch_addr,
  output logic [STATE_W-1:0]            state,
  output logic                          done,
  output logic                          trapped,
  output logic                          hung,
  output logic                          timed_out,
  output logic [CYC_W-1:0]              cycle_count,
  output logic [CYC_W-1:0]              end_cycle,
  output logic [DATA_W-1:0]             done_value,
  output logic [CYC_W-1:0]              wr_count,
  output logic [CYC_W-1:0]              rd_count,
  output logic [CYC_W-1:0]              stall_count,
  output logic [NUM_WATCH-1:0]          watch_hit,
  output logic [NUM_WATCH*DATA_W-1:0]   watch_data
);

  localparam logic [CYC_W-1:0] TO_LAST_C   = CYC_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CYC_W-1:0] STALL_LIM_C = CYC_W'(STALL_LIMIT);

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + CYC_W'(1);
  endfunction

  state_e            state_d, state_q;
  logic [CYC_W-1:0]  cycle_count_d, cycle_count_q;
  logic [CYC_W-1:0]  end_cycle_d,   end_cycle_q;
  logic [DATA_W-1:0] done_value_d,  done_value_q;
  logic [CYC_W-1:0]  wr_count_d,    wr_count_q;
  logic [CYC_W-1:0]  rd_count_d,    rd_count_q;
  logic [CYC_W-1:0]  stall_count_d, stall_count_q;
  logic [CYC_W-1:0]  stall_run_d,   stall_run_q;

  logic             xfer, wr_xfer, rd_xfer, stall_cyc, in_run;
  logic             done_hit, hang_hit, timeout_hit;
  logic [CYC_W-1:0] stall_run_inc;
  term_flags_t      flags;
  logic             unused_rdata;

  assign xfer          = bus.mem_valid & bus.mem_ready;
  assign wr_xfer       = xfer & (|bus.mem_wstrb);
  assign rd_xfer       = xfer & ~(|bus.mem_wstrb);
  assign stall_cyc     = bus.mem_valid & ~bus.mem_ready;
  assign in_run        = (state_q == ST_RUN);
  assign stall_run_inc = sat_inc(stall_run_q);
  assign done_hit      = wr_xfer && (bus.mem_addr == DONE_ADDR);
  assign hang_hit      = stall_cyc && (stall_run_inc >= STALL_LIM_C);
  assign timeout_hit   = (cycle_count_q == TO_LAST_C);
  assign unused_rdata  = ^bus.mem_rdata;

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: clear wins everywhere, then TRAP > DONE > HANG > TIMEOUT.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (enable) state_d = ST_RUN;
        ST_RUN: begin
          if (trap)             state_d = ST_TRAP;
          else if (done_hit)    state_d = ST_DONE;
          else if (hang_hit)    state_d = ST_HANG;
          else if (timeout_hit) state_d = ST_TIMEOUT;
        end
        ST_DONE, ST_TRAP, ST_HANG, ST_TIMEOUT: state_d = state_q;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: flags decode straight from the registered state.
  always_comb begin
    flags     = flags_of(state_q);
    state     = state_q;
    done      = flags.done;
    trapped   = flags.trapped;
    hung      = flags.hung;
    timed_out = flags.timed_out;
  end

  // Counters and captures advance only in RUN; the terminating cycle's events still count.
  always_comb begin
    cycle_count_d = cycle_count_q;
    end_cycle_d   = end_cycle_q;
    done_value_d  = done_value_q;
    wr_count_d    = wr_count_q;
    rd_count_d    = rd_count_q;
    stall_count_d = stall_count_q;
    stall_run_d   = stall_run_q;
    if (clear) begin
      cycle_count_d = '0;
      end_cycle_d   = '0;
      done_value_d  = '0;
      wr_count_d    = '0;
      rd_count_d    = '0;
      stall_count_d = '0;
      stall_run_d   = '0;
    end else if (in_run) begin
      cycle_count_d = sat_inc(cycle_count_q);
      if (wr_xfer)   wr_count_d    = sat_inc(wr_count_q);
      if (rd_xfer)   rd_count_d    = sat_inc(rd_count_q);
      if (stall_cyc) stall_count_d = sat_inc(stall_count_q);
      stall_run_d = stall_cyc ? stall_run_inc : '0;
      if (state_d != ST_RUN) end_cycle_d  = cycle_count_q;
      if (state_d == ST_DONE) done_value_d = bus.mem_wdata;
    end
  end

  // Counter and capture registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle_count_q <= '0;
      end_cycle_q   <= '0;
      done_value_q  <= '0;
      wr_count_q    <= '0;
      rd_count_q    <= '0;
      stall_count_q <= '0;
      stall_run_q   <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      end_cycle_q   <= end_cycle_d;
      done_value_q  <= done_value_d;
      wr_count_q    <= wr_count_d;
      rd_count_q    <= rd_count_d;
      stall_count_q <= stall_count_d;
      stall_run_q   <= stall_run_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign end_cycle   = end_cycle_q;
  assign done_value  = done_value_q;
  assign wr_count    = wr_count_q;
  assign rd_count    = rd_count_q;
  assign stall_count = stall_count_q;

  for (genvar i = 0; i < NUM_WATCH; i++) begin : g_watch
    bus_watch_chan #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_chan (
      .clk        (clk),
      .resetn     (resetn),
      .active     (in_run),
      .clear      (clear),
      .wr_xfer    (wr_xfer),
      .mem_addr   (bus.mem_addr),
      .mem_wstrb  (bus.mem_wstrb),
      .mem_wdata  (bus.mem_wdata),
      .watch_addr (watch_addr[i*ADDR_W +: ADDR_W]),
      .hit        (watch_hit[i]),
      .data       (watch_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_bus_mon_watchdog.sv
// Directed self-checking bench for bus_mon_watchdog (TIMEOUT_CYCLES=16, STALL_LIMIT=4).
module tb_bus_mon_watchdog;

  logic        clk = 1'b0;
  logic        resetn, enable, clear, trap;
  logic [63:0] watch_addr;
  logic [2:0]  state;
  logic        done, trapped, hung, timed_out;
  logic [31:0] cycle_count, end_cycle, done_value, wr_count, rd_count, stall_count;
  logic [1:0]  watch_hit;
  logic [63:0] watch_data;

  int cmp_cnt = 0;
  int err_cnt = 0;

  bus_mon_watchdog_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  bus_mon_watchdog #(
    .ADDR_W(32), .DATA_W(32), .NUM_WATCH(2), .CYC_W(32),
    .DONE_ADDR(32'h0000_0010), .TIMEOUT_CYCLES(16), .STALL_LIMIT(4)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear), .bus(bus_if),
    .trap(trap), .watch_addr(watch_addr), .state(state), .done(done),
    .trapped(trapped), .hung(hung), .timed_out(timed_out),
    .cycle_count(cycle_count), .end_cycle(end_cycle), .done_value(done_value),
    .wr_count(wr_count), .rd_count(rd_count), .stall_count(stall_count),
    .watch_hit(watch_hit), .watch_data(watch_data)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic r, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    bus_if.mem_valid = v;
    bus_if.mem_ready = r;
    bus_if.mem_addr  = a;
    bus_if.mem_wstrb = s;
    bus_if.mem_wdata = d;
    bus_if.mem_rdata = 32'h5A5A_5A5A;
  endtask

  task automatic bus_idle();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    enable = 1'b1;
    step();
    enable = 1'b0;
  endtask

  task automatic do_clear();
    bus_idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    cmp_cnt++; if (state !== 3'd0) begin err_cnt++; $display("FAIL reset_state got %0d exp 0", state); end
    cmp_cnt++; if ({done, trapped, hung, timed_out} !== 4'b0) begin err_cnt++; $display("FAIL reset_flags got %b exp 0000", {done, trapped, hung, timed_out}); end
    cmp_cnt++; if ({cycle_count, end_cycle, done_value, wr_count, rd_count, stall_count} !== 192'b0) begin err_cnt++; $display("FAIL reset_counters not all zero"); end
    cmp_cnt++; if ({watch_hit, watch_data} !== 66'b0) begin err_cnt++; $display("FAIL reset_watch got %b / %h exp 0", watch_hit, watch_data); end
  endtask

  task automatic test_idle_ignores_bus();
    drive(1'b1, 1'b1, 32'h100, 4'hF, 32'h1234_5678);
    step();
    bus_idle();
    cmp_cnt++; if (wr_count !== 32'd0) begin err_cnt++; $display("FAIL idle_wr_count got %0d exp 0", wr_count); end
    cmp_cnt++; if (watch_hit !== 2'b00) begin err_cnt++; $display("FAIL idle_watch_hit got %b exp 00", watch_hit); end
    cmp_cnt++; if (state !== 3'd0) begin err_cnt++; $display("FAIL idle_state got %0d exp 0", state); end
  endtask

  task automatic test_done();
    start_run();
    cmp_cnt++; if (state !== 3'd1) begin err_cnt++; $display("FAIL done_run_state got %0d exp 1", state); end
    cmp_cnt++; if (cycle_count !== 32'd0) begin err_cnt++; $display("FAIL done_first_cycle got %0d exp 0", cycle_count); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h40 + 32'(i*4), 4'h0, 32'h0);
      step();
    end
    bus_idle();
    repeat (4) step();
    drive(1'b1, 1'b1, 32'h10, 4'hF, 32'hCAFE_F00D);
    step();
    bus_idle();
    cmp_cnt++; if (state !== 3'd2 || done !== 1'b1) begin err_cnt++; $display("FAIL done_state got %0d/%b exp 2/1", state, done); end
    cmp_cnt++; if (done_value !== 32'hCAFE_F00D) begin err_cnt++; $display("FAIL done_value got %h exp cafef00d", done_value); end
    cmp_cnt++; if (end_cycle !== 32'd7) begin err_cnt++; $display("FAIL done_end_cycle got %0d exp 7", end_cycle); end
    cmp_cnt++; if (rd_count !== 32'd3 || wr_count !== 32'd1) begin err_cnt++; $display("FAIL done_rw_count got rd=%0d wr=%0d exp 3/1", rd_count, wr_count); end
    cmp_cnt++; if (cycle_count !== 32'd8) begin err_cnt++; $display("FAIL done_cycle_count got %0d exp 8", cycle_count); end
    drive(1'b1, 1'b1, 32'h40, 4'h0, 32'h0);
    step();
    bus_idle();
    cmp_cnt++; if (rd_count !== 32'd3 || cycle_count !== 32'd8) begin err_cnt++; $display("FAIL done_frozen got rd=%0d cyc=%0d exp 3/8", rd_count, cycle_count); end
    do_clear();
    cmp_cnt++; if (state !== 3'd0 || done !== 1'b0 || done_value !== 32'd0) begin err_cnt++; $display("FAIL done_clear got st=%0d done=%b val=%h exp 0/0/0", state, done, done_value); end
  endtask

  task automatic test_trap();
    start_run();
    trap = 1'b1;
    drive(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    step();
    trap = 1'b0;
    bus_idle();
    cmp_cnt++; if (state !== 3'd3) begin err_cnt++; $display("FAIL trap_state got %0d exp 3", state); end
    cmp_cnt++; if (trapped !== 1'b1 || done !== 1'b0) begin err_cnt++; $display("FAIL trap_flags got trapped=%b done=%b exp 1/0", trapped, done); end
    cmp_cnt++; if (done_value !== 32'd0) begin err_cnt++; $display("FAIL trap_done_value got %h exp 0", done_value); end
    cmp_cnt++; if (end_cycle !== 32'd0 || wr_count !== 32'd1) begin err_cnt++; $display("FAIL trap_counts got end=%0d wr=%0d exp 0/1", end_cycle, wr_count); end
    do_clear();
  endtask

  task automatic test_hang();
    start_run();
    drive(1'b1, 1'b0, 32'h80, 4'h0, 32'h0);
    repeat (3) step();
    drive(1'b1, 1'b1, 32'h80, 4'h0, 32'h0);
    step();
    drive(1'b1, 1'b0, 32'h84, 4'h0, 32'h0);
    repeat (3) step();
    cmp_cnt++; if (state !== 3'd1) begin err_cnt++; $display("FAIL hang_early got %0d exp 1", state); end
    step();
    bus_idle();
    cmp_cnt++; if (state !== 3'd4 || hung !== 1'b1) begin err_cnt++; $display("FAIL hang_state got %0d/%b exp 4/1", state, hung); end
    cmp_cnt++; if (stall_count !== 32'd7) begin err_cnt++; $display("FAIL hang_stall_count got %0d exp 7", stall_count); end
    cmp_cnt++; if (rd_count !== 32'd1 || end_cycle !== 32'd7) begin err_cnt++; $display("FAIL hang_counts got rd=%0d end=%0d exp 1/7", rd_count, end_cycle); end
    do_clear();
  endtask

  task automatic test_timeout();
    start_run();
    repeat (15) step();
    cmp_cnt++; if (state !== 3'd1 || cycle_count !== 32'd15) begin err_cnt++; $display("FAIL timeout_early got st=%0d cyc=%0d exp 1/15", state, cycle_count); end
    step();
    cmp_cnt++; if (state !== 3'd5 || timed_out !== 1'b1) begin err_cnt++; $display("FAIL timeout_state got %0d/%b exp 5/1", state, timed_out); end
    cmp_cnt++; if (end_cycle !== 32'd15 || cycle_count !== 32'd16) begin err_cnt++; $display("FAIL timeout_counts got end=%0d cyc=%0d exp 15/16", end_cycle, cycle_count); end
    do_clear();
    cmp_cnt++; if (state !== 3'd0 || cycle_count !== 32'd0 || timed_out !== 1'b0) begin err_cnt++; $display("FAIL timeout_clear got st=%0d cyc=%0d to=%b exp 0/0/0", state, cycle_count, timed_out); end
  endtask

  task automatic test_watch();
    start_run();
    drive(1'b1, 1'b1, 32'h100, 4'hF, 32'h1122_3344);
    step();
    cmp_cnt++; if (watch_hit !== 2'b01 || watch_data[31:0] !== 32'h1122_3344) begin err_cnt++; $display("FAIL watch_first got hit=%b d0=%h exp 01/11223344", watch_hit, watch_data[31:0]); end
    drive(1'b1, 1'b1, 32'h100, 4'b0101, 32'hAABB_CCDD);
    step();
    cmp_cnt++; if (watch_data[31:0] !== 32'h11BB_33DD) begin err_cnt++; $display("FAIL watch_merge got %h exp 11bb33dd", watch_data[31:0]); end
    drive(1'b1, 1'b1, 32'h100, 4'h0, 32'hFFFF_FFFF);
    step();
    cmp_cnt++; if (watch_hit !== 2'b01 || watch_data !== 64'h0000_0000_11BB_33DD) begin err_cnt++; $display("FAIL watch_read got hit=%b d=%h exp 01/0000000011bb33dd", watch_hit, watch_data); end
    drive(1'b1, 1'b1, 32'h200, 4'b1100, 32'h5566_7788);
    step();
    bus_idle();
    cmp_cnt++; if (watch_hit !== 2'b11 || watch_data[63:32] !== 32'h5566_0000) begin err_cnt++; $display("FAIL watch_ch1 got hit=%b d1=%h exp 11/55660000", watch_hit, watch_data[63:32]); end
    do_clear();
    cmp_cnt++; if (watch_hit !== 2'b00 || watch_data !== 64'd0) begin err_cnt++; $display("FAIL watch_clear got hit=%b d=%h exp 0", watch_hit, watch_data); end
  endtask

  task automatic test_back_to_back();
    start_run();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 32'h300, (i % 2 == 0) ? 4'hF : 4'h0, 32'(i));
      step();
    end
    bus_idle();
    cmp_cnt++; if (wr_count !== 32'd3 || rd_count !== 32'd2) begin err_cnt++; $display("FAIL b2b_counts got wr=%0d rd=%0d exp 3/2", wr_count, rd_count); end
    cmp_cnt++; if (cycle_count !== 32'd5 || stall_count !== 32'd0) begin err_cnt++; $display("FAIL b2b_cycles got cyc=%0d stall=%0d exp 5/0", cycle_count, stall_count); end
    do_clear();
  endtask

  task automatic test_async_reset();
    start_run();
    drive(1'b1, 1'b1, 32'h100, 4'hF, 32'h0BAD_F00D);
    step();
    drive(1'b1, 1'b1, 32'h60, 4'h0, 32'h0);
    step();
    bus_idle();
    cmp_cnt++; if (state !== 3'd1 || watch_hit !== 2'b01 || cycle_count !== 32'd2) begin err_cnt++; $display("FAIL arst_pre got st=%0d hit=%b cyc=%0d exp 1/01/2", state, watch_hit, cycle_count); end
    #2;
    resetn = 1'b0;
    #1;
    cmp_cnt++; if (state !== 3'd0) begin err_cnt++; $display("FAIL arst_state got %0d exp 0", state); end
    cmp_cnt++; if ({cycle_count, wr_count, rd_count, watch_hit, watch_data} !== 162'b0) begin err_cnt++; $display("FAIL arst_outputs not all zero"); end
    resetn = 1'b1;
    step();
    cmp_cnt++; if (state !== 3'd0) begin err_cnt++; $display("FAIL arst_after got %0d exp 0", state); end
  endtask

  initial begin
    resetn     = 1'b0;
    enable     = 1'b0;
    clear      = 1'b0;
    trap       = 1'b0;
    watch_addr = {32'h0000_0200, 32'h0000_0100};
    bus_idle();
    repeat (2) step();
    test_reset();
    resetn = 1'b1;
    step();
    test_idle_ignores_bus();
    test_done();
    test_trap();
    test_hang();
    test_timeout();
    test_watch();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
